// File: rtl/l2_bank_req_buffer.sv
// ---------------------------------------------------------------------------
// l2_bank_req_buffer
//
// Two-entry in-order request buffer between the root of the L2 request fan-in
// tree and a single L2 SRAM bank. Requests are accepted from the fan-in side,
// presented to the bank from the head entry, and a response (valid, ID, read
// data) is returned one cycle after each bank grant.
//
// Handshake semantics (both sides are req/gnt):
//   - Upstream: a request transfers in any cycle where data_req_i and
//     data_gnt_o are both high. data_gnt_o depends only on data_req_i and
//     the buffer occupancy, never on mem_gnt_i.
//   - Downstream: the head entry transfers in any cycle where mem_req_o and
//     mem_gnt_i are both high. mem_req_o stays high while any entry is held.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   data_*_i         request from the fan-in root (add, wen, wdata, wtag, be, ID)
//   data_gnt_o       request accepted this cycle
//   mem_req_o        head entry valid towards the bank
//   mem_*_o          head entry fields
//   mem_gnt_i        bank accepted the head entry
//   mem_rdata_i      bank read data, valid the cycle after a grant
//   data_r_valid_o   response valid (reads and writes)
//   data_r_ID_o      response ID
//   data_r_rdata_o   response read data
//   stall_cnt_o      (only with L2_REQ_BUF_STATS_EN) saturating count of
//                    cycles with mem_req_o high and mem_gnt_i low
//
// Optional feature macro: L2_REQ_BUF_STATS_EN
// ---------------------------------------------------------------------------
module l2_bank_req_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 16,
    parameter int DATA_WIDTH = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int TAG_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_add_i,
    input  logic                  data_wen_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    input  logic [TAG_WIDTH-1:0]  data_wtag_i,
    input  logic [BE_WIDTH-1:0]   data_be_i,
    input  logic [ID_WIDTH-1:0]   data_ID_i,
    output logic                  data_gnt_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_add_o,
    output logic                  mem_wen_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [TAG_WIDTH-1:0]  mem_wtag_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  data_r_valid_o,
    output logic [ID_WIDTH-1:0]   data_r_ID_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o
`ifdef L2_REQ_BUF_STATS_EN
    ,
    output logic [15:0]           stall_cnt_o
`endif
);

    // Entry storage; intentionally not reset, occupancy is tracked by count_q.
    logic [ADDR_WIDTH-1:0] add_q   [2];
    logic                  wen_q   [2];
    logic [DATA_WIDTH-1:0] wdata_q [2];
    logic [TAG_WIDTH-1:0]  wtag_q  [2];
    logic [BE_WIDTH-1:0]   be_q    [2];
    logic [ID_WIDTH-1:0]   id_q    [2];

    logic [1:0]          count_q, count_d;
    logic                wptr_q, wptr_d;
    logic                rptr_q, rptr_d;
    logic                r_valid_q, r_valid_d;
    logic [ID_WIDTH-1:0] r_id_q, r_id_d;

    logic push;
    logic pop;

    // When full no push happens, even if the head pops in the same cycle.
    assign data_gnt_o = data_req_i & (count_q != 2'd2);
    assign push       = data_req_i & data_gnt_o;
    assign mem_req_o  = (count_q != 2'd0);
    assign pop        = mem_req_o & mem_gnt_i;

    assign mem_add_o   = add_q[rptr_q];
    assign mem_wen_o   = wen_q[rptr_q];
    assign mem_wdata_o = wdata_q[rptr_q];
    assign mem_wtag_o  = wtag_q[rptr_q];
    assign mem_be_o    = be_q[rptr_q];

    always_comb begin
        count_d   = count_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        r_valid_d = pop;
        r_id_d    = r_id_q;
        if (push) begin
            wptr_d = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
            r_id_d = id_q[rptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= 2'd0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
        end else begin
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            r_valid_q <= r_valid_d;
            r_id_q    <= r_id_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            add_q[wptr_q]   <= data_add_i;
            wen_q[wptr_q]   <= data_wen_i;
            wdata_q[wptr_q] <= data_wdata_i;
            wtag_q[wptr_q]  <= data_wtag_i;
            be_q[wptr_q]    <= data_be_i;
            id_q[wptr_q]    <= data_ID_i;
        end
    end

    assign data_r_valid_o = r_valid_q;
    assign data_r_ID_o    = r_id_q;
    // Bank data arrives the cycle after grant, aligned with the response valid.
    assign data_r_rdata_o = r_valid_q ? mem_rdata_i : '0;

`ifdef L2_REQ_BUF_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (mem_req_o && !mem_gnt_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_l2_bank_req_buffer.sv
module tb_l2_bank_req_buffer;

    localparam int AW = 32;
    localparam int IW = 16;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int TW = DW / 8;

    typedef struct packed {
        logic [AW-1:0] add;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [TW-1:0] wtag;
        logic [BW-1:0] be;
        logic [IW-1:0] id;
    } req_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          data_req_i = 1'b0;
    logic [AW-1:0] data_add_i = '0;
    logic          data_wen_i = 1'b0;
    logic [DW-1:0] data_wdata_i = '0;
    logic [TW-1:0] data_wtag_i = '0;
    logic [BW-1:0] data_be_i = '0;
    logic [IW-1:0] data_ID_i = '0;
    logic          data_gnt_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_add_o;
    logic          mem_wen_o;
    logic [DW-1:0] mem_wdata_o;
    logic [TW-1:0] mem_wtag_o;
    logic [BW-1:0] mem_be_o;
    logic          mem_gnt_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          data_r_valid_o;
    logic [IW-1:0] data_r_ID_o;
    logic [DW-1:0] data_r_rdata_o;
`ifdef L2_REQ_BUF_STATS_EN
    logic [15:0]   stall_cnt_o;
`endif

    l2_bank_req_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .data_req_i     (data_req_i),
        .data_add_i     (data_add_i),
        .data_wen_i     (data_wen_i),
        .data_wdata_i   (data_wdata_i),
        .data_wtag_i    (data_wtag_i),
        .data_be_i      (data_be_i),
        .data_ID_i      (data_ID_i),
        .data_gnt_o     (data_gnt_o),
        .mem_req_o      (mem_req_o),
        .mem_add_o      (mem_add_o),
        .mem_wen_o      (mem_wen_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_wtag_o     (mem_wtag_o),
        .mem_be_o       (mem_be_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rdata_i    (mem_rdata_i),
        .data_r_valid_o (data_r_valid_o),
        .data_r_ID_o    (data_r_ID_o),
        .data_r_rdata_o (data_r_rdata_o)
`ifdef L2_REQ_BUF_STATS_EN
        ,
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    // ---------------- reference model ----------------
    // Accepted-but-not-issued requests, in acceptance order.
    req_t          exp_q[$];
    logic          exp_rv = 1'b0;   // response expected in the current cycle
    logic [IW-1:0] exp_rid = '0;    // ID the response register should show
    int            exp_stall = 0;

    int errors = 0;
    int checks = 0;

    function automatic req_t mk(input logic [IW-1:0] id, input logic [AW-1:0] add,
                                input logic wen);
        req_t r;
        r.add   = add;
        r.wen   = wen;
        r.wdata = {$urandom, $urandom};
        r.wtag  = TW'($urandom);
        r.be    = BW'($urandom);
        r.id    = id;
        return r;
    endfunction

    // Drive all inputs at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic r_rst, input logic req, input req_t r,
                         input logic gnt, input logic [DW-1:0] rd);
        @(negedge clk);
        rst          = r_rst;
        data_req_i   = req;
        data_add_i   = r.add;
        data_wen_i   = r.wen;
        data_wdata_i = r.wdata;
        data_wtag_i  = r.wtag;
        data_be_i    = r.be;
        data_ID_i    = r.id;
        mem_gnt_i    = gnt;
        mem_rdata_i  = rd;
        #1;
    endtask

    // Advance the model across the next rising edge using the current inputs.
    task automatic advance();
        logic do_push, do_pop;
        req_t head;
        do_pop  = (exp_q.size() != 0) && mem_gnt_i;
        do_push = data_req_i && (exp_q.size() < 2);
        head    = (exp_q.size() != 0) ? exp_q[0] : '0;
        if (!rst && (exp_q.size() != 0) && !mem_gnt_i && exp_stall < 65535)
            exp_stall++;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_rv    = 1'b0;
            exp_rid   = '0;
            exp_stall = 0;
        end else begin
            exp_rv = do_pop;
            if (do_pop) begin
                exp_rid = head.id;
                void'(exp_q.pop_front());
            end
            if (do_push) exp_q.push_back({data_add_i, data_wen_i, data_wdata_i,
                                          data_wtag_i, data_be_i, data_ID_i});
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1'b1, 1'b0, mk(16'h0, 32'h0, 1'b0), 1'b0, '0);
        checks++; if (mem_req_o !== 1'b0) begin errors++;
            $display("FAIL reset_mem_req: got %b expected 0", mem_req_o); end
        checks++; if (data_gnt_o !== 1'b0) begin errors++;
            $display("FAIL reset_gnt_idle: got %b expected 0", data_gnt_o); end
        checks++; if (data_r_valid_o !== 1'b0) begin errors++;
            $display("FAIL reset_r_valid: got %b expected 0", data_r_valid_o); end
        checks++; if (data_r_ID_o !== '0) begin errors++;
            $display("FAIL reset_r_id: got %h expected 0", data_r_ID_o); end
        advance();
        drive(1'b1, 1'b1, mk(16'h7, 32'h40, 1'b1), 1'b0, '0);
        checks++; if (data_gnt_o !== 1'b1) begin errors++;
            $display("FAIL reset_gnt_req: got %b expected 1", data_gnt_o); end
        advance();
        drive(1'b0, 1'b0, mk(16'h0, 32'h0, 1'b0), 1'b0, '0);
        checks++; if (mem_req_o !== 1'b0) begin errors++;
            $display("FAIL reset_release_empty: got %b expected 0", mem_req_o); end
        advance();
    endtask

    task automatic test_single_read();
        req_t r;
        r = mk(16'h0003, 32'h100, 1'b1);
        drive(1'b0, 1'b1, r, 1'b1, '0);
        checks++; if (data_gnt_o !== 1'b1) begin errors++;
            $display("FAIL single_gnt: got %b expected 1", data_gnt_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++;
            $display("FAIL single_no_bypass: got %b expected 0", mem_req_o); end
        advance();
        drive(1'b0, 1'b0, mk(16'h0, 32'h0, 1'b0), 1'b1, '0);
        checks++; if (mem_req_o !== 1'b1) begin errors++;
            $display("FAIL single_mem_req: got %b expected 1", mem_req_o); end
        checks++; if (mem_add_o !== 32'h100 || mem_wen_o !== 1'b1) begin errors++;
            $display("FAIL single_mem_fields: got add=%h wen=%b expected add=100 wen=1",
                     mem_add_o, mem_wen_o); end
        advance();
        drive(1'b0, 1'b0, mk(16'h0, 32'h0, 1'b0), 1'b0, 64'hDEADBEEF_00000001);
        checks++; if (data_r_valid_o !== 1'b1 || data_r_ID_o !== 16'h0003) begin errors++;
            $display("FAIL single_resp: got valid=%b id=%h expected valid=1 id=0003",
                     data_r_valid_o, data_r_ID_o); end
        checks++; if (data_r_rdata_o !== 64'hDEADBEEF_00000001) begin errors++;
            $display("FAIL single_rdata: got %h expected deadbeef00000001", data_r_rdata_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++;
            $display("FAIL single_empty: got %b expected 0", mem_req_o); end
        advance();
        drive(1'b0, 1'b0, mk(16'h0, 32'h0, 1'b0), 1'b0, '0);
        checks++; if (data_r_valid_o !== 1'b0) begin errors++;
            $display("FAIL single_resp_once: got %b expected 0", data_r_valid_o); end
        advance();
    endtask

    task automatic test_fill_drain();
        logic [IW-1:0] id_seq[$];
        logic [IW-1:0] next_id;
        logic          want_gnt;
        int            resp_seen;
        next_id   = 16'd1;
        resp_seen = 0;
        id_seq    = {16'd1, 16'd2, 16'd3};
        // Four stalled cycles, then release the bank and drain.
        for (int cyc = 0; cyc < 10; cyc++) begin
            logic g;
            logic rq;
            g  = (cyc >= 4);
            rq = (next_id <= 16'd3);
            drive(1'b0, rq, mk(next_id, {12'h0, next_id, 4'h0}, 1'b0), g, 64'(cyc));
            want_gnt = rq && (exp_q.size() < 2);
            checks++; if (data_gnt_o !== want_gnt) begin errors++;
                $display("FAIL fill_gnt id=%0d cyc=%0d: got %b expected %b",
                         next_id, cyc, data_gnt_o, want_gnt); end
            if (cyc == 2 || cyc == 3 || cyc == 4) begin
                checks++; if (data_gnt_o !== 1'b0) begin errors++;
                    $display("FAIL fill_full_block cyc=%0d: got %b expected 0", cyc, data_gnt_o); end
            end
            checks++; if (data_r_valid_o !== exp_rv) begin errors++;
                $display("FAIL fill_r_valid cyc=%0d: got %b expected %b", cyc, data_r_valid_o, exp_rv); end
            if (exp_rv) begin
                checks++; if (data_r_ID_o !== id_seq[resp_seen]) begin errors++;
                    $display("FAIL fill_order cyc=%0d: got %h expected %h",
                             cyc, data_r_ID_o, id_seq[resp_seen]); end
                resp_seen++;
            end
            if (data_gnt_o === 1'b1 && rq) next_id++;
            advance();
        end
        checks++; if (resp_seen != 3) begin errors++;
            $display("FAIL fill_resp_count: got %0d expected 3", resp_seen); end
    endtask

    task automatic test_streaming();
        logic [IW-1:0] id;
        drive(1'b0, 1'b1, mk(16'h0100, 32'h1000, 1'b1), 1'b0, '0);
        advance();
        for (int i = 0; i < 8; i++) begin
            id = 16'h0101 + 16'(i);
            drive(1'b0, 1'b1, mk(id, 32'h1000 + 32'(i * 4 + 4), 1'b1), 1'b1, {32'hCAFE0000, 32'(i)});
            checks++; if (data_gnt_o !== 1'b1 || mem_req_o !== 1'b1) begin errors++;
                $display("FAIL stream_handshake i=%0d: got gnt=%b req=%b expected 1 1",
                         i, data_gnt_o, mem_req_o); end
            checks++; if (mem_add_o !== 32'h1000 + 32'(i * 4)) begin errors++;
                $display("FAIL stream_head_add i=%0d: got %h expected %h",
                         i, mem_add_o, 32'h1000 + 32'(i * 4)); end
            if (i > 0) begin
                checks++; if (data_r_valid_o !== 1'b1 || data_r_ID_o !== id - 16'd2) begin errors++;
                    $display("FAIL stream_resp i=%0d: got valid=%b id=%h expected valid=1 id=%h",
                             i, data_r_valid_o, data_r_ID_o, id - 16'd2); end
            end
            advance();
        end
        // Drain the remaining entry.
        drive(1'b0, 1'b0, mk(16'h0, 32'h0, 1'b0), 1'b1, '0);
        advance();
        drive(1'b0, 1'b0, mk(16'h0, 32'h0, 1'b0), 1'b0, '0);
        checks++; if (data_r_valid_o !== 1'b1 || data_r_ID_o !== 16'h0108) begin errors++;
            $display("FAIL stream_last: got valid=%b id=%h expected valid=1 id=0108",
                     data_r_valid_o, data_r_ID_o); end
        advance();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, mk(16'h0AA1, 32'h200, 1'b0), 1'b0, '0);
        advance();
        drive(1'b0, 1'b1, mk(16'h0AA2, 32'h204, 1'b1), 1'b0, '0);
        advance();
        drive(1'b1, 1'b0, mk(16'h0, 32'h0, 1'b0), 1'b1, '0);
        checks++; if (mem_req_o !== 1'b0) begin errors++;
            $display("FAIL midrst_mem_req: got %b expected 0", mem_req_o); end
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, mk(16'h0, 32'h0, 1'b0), 1'b1, '0);
            checks++; if (data_r_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++;
                $display("FAIL midrst_no_resp i=%0d: got valid=%b req=%b expected 0 0",
                         i, data_r_valid_o, mem_req_o); end
            advance();
        end
    endtask

    task automatic test_random();
        logic          rq, g;
        logic [DW-1:0] rd;
        logic          want_gnt;
        req_t          h;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rq = ($urandom_range(0, 99) < 60);
            g  = ($urandom_range(0, 99) < 50);
            rd = {$urandom, $urandom};
            drive(1'b0, rq, mk(IW'($urandom), $urandom, 1'($urandom)), g, rd);
            want_gnt = rq && (exp_q.size() < 2);
            checks++; if (data_gnt_o !== want_gnt || mem_req_o !== (exp_q.size() != 0)) begin errors++;
                $display("FAIL rand_handshake cyc=%0d: got gnt=%b req=%b expected gnt=%b req=%b",
                         cyc, data_gnt_o, mem_req_o, want_gnt, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                h = exp_q[0];
                checks++;
                if (mem_add_o !== h.add || mem_wen_o !== h.wen || mem_wdata_o !== h.wdata ||
                    mem_wtag_o !== h.wtag || mem_be_o !== h.be) begin errors++;
                    $display("FAIL rand_head cyc=%0d: got add=%h wen=%b wdata=%h tag=%h be=%h expected add=%h wen=%b wdata=%h tag=%h be=%h",
                             cyc, mem_add_o, mem_wen_o, mem_wdata_o, mem_wtag_o, mem_be_o,
                             h.add, h.wen, h.wdata, h.wtag, h.be); end
            end
            checks++; if (data_r_valid_o !== exp_rv) begin errors++;
                $display("FAIL rand_r_valid cyc=%0d: got %b expected %b", cyc, data_r_valid_o, exp_rv); end
            if (exp_rv) begin
                checks++; if (data_r_ID_o !== exp_rid || data_r_rdata_o !== rd) begin errors++;
                    $display("FAIL rand_resp cyc=%0d: got id=%h rdata=%h expected id=%h rdata=%h",
                             cyc, data_r_ID_o, data_r_rdata_o, exp_rid, rd); end
            end
`ifdef L2_REQ_BUF_STATS_EN
            checks++; if (stall_cnt_o !== 16'(exp_stall)) begin errors++;
                $display("FAIL rand_stall cyc=%0d: got %0d expected %0d", cyc, stall_cnt_o, exp_stall); end
`endif
            advance();
        end
    endtask

`ifdef L2_REQ_BUF_STATS_EN
    task automatic test_stats();
        drive(1'b1, 1'b0, mk(16'h0, 32'h0, 1'b0), 1'b0, '0);
        checks++; if (stall_cnt_o !== 16'h0) begin errors++;
            $display("FAIL stats_reset: got %h expected 0", stall_cnt_o); end
        advance();
        drive(1'b0, 1'b1, mk(16'h0055, 32'h300, 1'b1), 1'b0, '0);
        advance();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, mk(16'h0, 32'h0, 1'b0), 1'b0, '0);
            advance();
        end
        drive(1'b0, 1'b0, mk(16'h0, 32'h0, 1'b0), 1'b0, '0);
        checks++; if (stall_cnt_o !== 16'd10) begin errors++;
            $display("FAIL stats_count10: got %0d expected 10", stall_cnt_o); end
        for (int i = 0; i < 70000; i++) begin
            advance();
            drive(1'b0, 1'b0, mk(16'h0, 32'h0, 1'b0), 1'b0, '0);
        end
        checks++; if (stall_cnt_o !== 16'hFFFF) begin errors++;
            $display("FAIL stats_saturate: got %h expected ffff", stall_cnt_o); end
        advance();
        drive(1'b0, 1'b0, mk(16'h0, 32'h0, 1'b0), 1'b0, '0);
        checks++; if (stall_cnt_o !== 16'hFFFF) begin errors++;
            $display("FAIL stats_hold: got %h expected ffff", stall_cnt_o); end
        advance();
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_fill_drain();
        test_streaming();
        test_reset_mid();
        test_random();
`ifdef L2_REQ_BUF_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l2_bank_req_buffer.md
Name: l2_bank_req_buffer

Overview:
- Sits directly downstream of the root of the L2 request fan-in tree.
- Accepts the single arbitrated request stream and buffers it in a 2-entry in-order FIFO.
- Issues requests to one L2 SRAM bank with a req/gnt handshake.
- Returns a response (valid, ID, read data) to the response routing path one cycle after each bank grant.

Parameters:
- ADDR_WIDTH, 32, request address width
- ID_WIDTH, 16, requester ID width; carried through to the response
- DATA_WIDTH, 64, write and read data width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- TAG_WIDTH, DATA_WIDTH/8, write tag width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- data_req_i  in  1  request from fan-in root
- data_add_i  in  ADDR_WIDTH  address
- data_wen_i  in  1  1 = read, 0 = write
- data_wdata_i  in  DATA_WIDTH  write data
- data_wtag_i  in  TAG_WIDTH  write tag
- data_be_i  in  BE_WIDTH  byte enables
- data_ID_i  in  ID_WIDTH  requester ID
- data_gnt_o  out  1  request accepted this cycle
- mem_req_o  out  1  request to bank
- mem_add_o  out  ADDR_WIDTH  head-entry address
- mem_wen_o  out  1  head-entry wen
- mem_wdata_o  out  DATA_WIDTH  head-entry write data
- mem_wtag_o  out  TAG_WIDTH  head-entry write tag
- mem_be_o  out  BE_WIDTH  head-entry byte enables
- mem_gnt_i  in  1  bank accepted head entry
- mem_rdata_i  in  DATA_WIDTH  bank read data, valid the cycle after grant
- data_r_valid_o  out  1  response valid (reads and writes)
- data_r_ID_o  out  ID_WIDTH  response ID
- data_r_rdata_o  out  DATA_WIDTH  response read data

Behaviour:
- Storage:
  - 2 entries: {add, wen, wdata, wtag, be, ID}.
  - 1-bit write pointer and 1-bit read pointer; both wrap modulo 2.
  - 2-bit count, range 0..2.
- Push / pop:
  - data_gnt_o = data_req_i & (count != 2). Purely combinational from count and data_req_i; no dependency on mem_gnt_i. When full, no push occurs even if a pop happens in the same cycle.
  - Push = data_req_i & data_gnt_o. Writes the entry at the write pointer, then advances the write pointer.
  - mem_req_o = (count != 0).
  - mem_* outputs are driven from the entry at the read pointer.
  - Pop = mem_req_o & mem_gnt_i. Advances the read pointer.
  - Simultaneous push and pop: count unchanged; both pointers advance.
  - count 0 with push: the entry is presented on mem_* in the next cycle. Fixed minimum latency is 1 cycle from data_gnt_o to mem_req_o; there is no bypass.
  - Empty: mem_* data outputs hold the stale head entry; they are don't-care while mem_req_o = 0.
- Response path:
  - data_r_valid_o is a register set to Pop.
  - data_r_ID_o is a register loaded with the head ID on Pop, otherwise held.
  - data_r_rdata_o = mem_rdata_i combinationally, qualified only by data_r_valid_o.
  - Write requests also produce data_r_valid_o; rdata is don't-care for them.
- Ordering: strict FIFO; responses return in acceptance order.
- Reset:
  - count = 0, both pointers = 0, data_r_valid_o = 0, data_r_ID_o = 0.
  - Therefore mem_req_o = 0; data_gnt_o = 0 while data_req_i is low.
  - Entry storage is not reset.
  - Reset mid-operation discards all buffered requests and any pending response. The first cycle after reset deassertion behaves as empty.

Optional Feature:
- Macro: L2_REQ_BUF_STATS_EN.
- Enabled:
  - Adds output port stall_cnt_o [15:0], a register cleared by rst.
  - Increments each cycle in which mem_req_o & ~mem_gnt_i.
  - Saturates at 16'hFFFF.
- Disabled: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset:
  - Assert rst with data_req_i = 0 -> mem_req_o = 0, data_gnt_o = 0, data_r_valid_o = 0, data_r_ID_o = 0.
  - Assert rst with data_req_i = 1 -> data_gnt_o = 1 combinationally.
- Single read:
  - Stimulus: req add = 0x100, ID = 0x0003, wen = 1, mem_gnt_i = 1, mem_rdata_i = 0xDEADBEEF_00000001 in the cycle after grant.
  - Required: mem_req_o one cycle after data_gnt_o; data_r_valid_o = 1 with ID 0x0003 and the rdata above one cycle after mem grant.
- Fill and drain:
  - Stimulus: mem_gnt_i = 0, continuous requests with IDs 1, 2, 3.
  - Required: IDs 1 and 2 granted; data_gnt_o = 0 for ID 3 while count = 2.
  - Release mem_gnt_i -> responses ID 1 then ID 2 on consecutive cycles; ID 3 granted only after count drops below 2.
- Streaming:
  - Stimulus: count = 1, continuous req and mem_gnt_i = 1 for 8 cycles.
  - Required: one grant and one response per cycle; count stays 1; IDs in order.
- Reset mid-operation:
  - Stimulus: 2 entries buffered, assert rst.
  - Required: mem_req_o = 0 immediately; no response emitted for the buffered IDs after release.
- Stats (L2_REQ_BUF_STATS_EN):
  - Hold mem_req_o = 1, mem_gnt_i = 0 for 70000 cycles -> stall_cnt_o = 16'hFFFF and held.
